// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if -- bundles the receiver-side write strobe, the CPU-side pop
// handshake and the status outputs of uart_rx_fifo.
//   master : drives rx_end/rx_data/flush/rd_req/ovf_clr, observes status/data
//   slave  : the FIFO itself
//   ADDR_W : pointer width; count is ADDR_W+1 bits wide (0..DEPTH)
interface uart_rx_fifo_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              rx_end;
  logic [7:0]        rx_data;
  logic              flush;
  logic              rd_req;
  logic              ovf_clr;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              irq;

  modport master (
    output rx_end, rx_data, flush, rd_req, ovf_clr,
    input  rd_data, rd_valid, empty, full, count, ovf, irq
  );

  modport slave (
    input  rx_end, rx_data, flush, rd_req, ovf_clr,
    output rd_data, rd_valid, empty, full, count, ovf, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- circular byte FIFO between a UART receiver and CPU bus logic.
// Captures rx_data on each rx_end strobe, pops one byte per accepted rd_req
// into a registered rd_data with a one-cycle rd_valid pulse, and reports
// occupancy, a sticky overflow flag and a level interrupt.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : uart_rx_fifo_if.slave (write strobe, pop handshake, status)
module uart_rx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned IRQ_LEVEL = 1
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_fifo_if.slave   bus
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] IRQ_CNT  = (ADDR_W+1)'(IRQ_LEVEL);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;

  logic              empty, full;
  logic              wr_acc, rd_acc, ovf_evt;

  // Status derives only from registers so it is glitch-free.
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A read on a full FIFO frees the slot the concurrent write needs, so the
  // write is accepted and no overflow is flagged. Flush masks both sides.
  assign rd_acc  = bus.rd_req & ~bus.flush & ~empty;
  assign wr_acc  = bus.rx_end & ~bus.flush & (~full | rd_acc);
  assign ovf_evt = bus.rx_end & ~bus.flush & full & ~rd_acc;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    // A same-cycle overflow beats ovf_clr.
    ovf_d      = ovf_evt | (ovf_q & ~bus.ovf_clr);

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
        rd_data_d = mem_q[rd_ptr_q];
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage is deliberately not reset; the read above sees the pre-edge value
  // even when write and read hit the same slot (full + simultaneous access).
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.ovf      = ovf_q;
  assign bus.irq      = (count_q >= IRQ_CNT) | ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned IRQ_LEVEL = 4;

  logic clk;
  logic reset;

  uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_fifo #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .IRQ_LEVEL (IRQ_LEVEL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue of stored bytes plus the registered outputs.
  logic [7:0] model_q [$];
  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ovf   = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned sz;
    sz = model_q.size();
    chk({tag, ".count"},    32'(bus.count),    sz);
    chk({tag, ".empty"},    32'(bus.empty),    32'(sz == 0));
    chk({tag, ".full"},     32'(bus.full),     32'(sz == DEPTH));
    chk({tag, ".ovf"},      32'(bus.ovf),      32'(exp_ovf));
    chk({tag, ".irq"},      32'(bus.irq),      32'((sz >= IRQ_LEVEL) || exp_ovf));
    chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(exp_valid));
    chk({tag, ".rd_data"},  32'(bus.rd_data),  32'(exp_data));
  endtask

  // One clock cycle: apply inputs, advance the model, check after the edge.
  task automatic step(input string tag, input logic re, input logic [7:0] d,
                      input logic rq, input logic fl, input logic oc);
    bit rd_ok, wr_ok;
    @(negedge clk);
    bus.rx_end  = re;
    bus.rx_data = d;
    bus.rd_req  = rq;
    bus.flush   = fl;
    bus.ovf_clr = oc;
    if (fl) begin
      model_q.delete();
      exp_valid = 1'b0;
      if (oc) exp_ovf = 1'b0;
    end else begin
      rd_ok = rq && (model_q.size() > 0);
      wr_ok = re && ((model_q.size() < DEPTH) || rd_ok);
      exp_valid = rd_ok;
      if (rd_ok) exp_data = model_q.pop_front();
      if (wr_ok) model_q.push_back(d);
      if (re && !wr_ok) exp_ovf = 1'b1;
      else if (oc)      exp_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic push(input string tag, input logic [7:0] d);
    step(tag, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop(input string tag);
    step(tag, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.rx_end  = 1'b0;
    bus.rx_data = 8'h00;
    bus.flush   = 1'b0;
    bus.rd_req  = 1'b0;
    bus.ovf_clr = 1'b0;
    reset = 1'b1;
    #3;
    chk("rst.count",    32'(bus.count),    0);
    chk("rst.empty",    32'(bus.empty),    1);
    chk("rst.full",     32'(bus.full),     0);
    chk("rst.ovf",      32'(bus.ovf),      0);
    chk("rst.irq",      32'(bus.irq),      0);
    chk("rst.rd_valid", 32'(bus.rd_valid), 0);
    chk("rst.rd_data",  32'(bus.rd_data),  0);
    @(negedge clk);
    reset = 1'b0;
    idle("idle0");

    // Two bytes in, two bytes out.
    push("tp1.w0", 8'hA5);
    push("tp1.w1", 8'h3C);
    chk("tp1.count2", 32'(bus.count), 2);
    pop("tp1.r0");
    chk("tp1.d0", 32'(bus.rd_data), 32'h A5);
    chk("tp1.v0", 32'(bus.rd_valid), 1);
    pop("tp1.r1");
    chk("tp1.d1", 32'(bus.rd_data), 32'h3C);
    chk("tp1.empty", 32'(bus.empty), 1);
    idle("tp1.idle");
    chk("tp1.v_low", 32'(bus.rd_valid), 0);

    // Fill, overflow, drain.
    for (int i = 0; i < 16; i++) push("tp2.fill", 8'(i));
    chk("tp2.full", 32'(bus.full), 1);
    chk("tp2.count16", 32'(bus.count), 16);
    push("tp2.ovfw", 8'hFF);
    chk("tp2.ovf", 32'(bus.ovf), 1);
    chk("tp2.irq", 32'(bus.irq), 1);
    for (int i = 0; i < 16; i++) begin
      pop("tp2.drain");
      chk("tp2.order", 32'(bus.rd_data), 32'(i));
    end
    pop("tp2.extra");
    chk("tp2.noFF", 32'(bus.rd_data), 32'h0F);

    // ovf_clr alone clears the sticky flag.
    step("tp5.clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("tp5.clr_ovf", 32'(bus.ovf), 0);

    // Full plus simultaneous write and read.
    for (int i = 0; i < 16; i++) push("tp3.fill", 8'(8'h80 + i));
    step("tp3.both", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("tp3.oldest", 32'(bus.rd_data), 32'h80);
    chk("tp3.count", 32'(bus.count), 16);
    chk("tp3.ovf0", 32'(bus.ovf), 0);

    // Overflow coincident with ovf_clr keeps ovf set; clear alone drops it.
    step("tp5.coinc", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("tp5.coinc_ovf", 32'(bus.ovf), 1);
    step("tp5.clr2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("tp5.clr2_ovf", 32'(bus.ovf), 0);
    for (int i = 0; i < 16; i++) pop("tp3.drain");
    chk("tp3.last77", 32'(bus.rd_data), 32'h77);

    // Pointer wrap.
    for (int i = 0; i < 10; i++) push("tp4.w", 8'($urandom));
    for (int i = 0; i < 10; i++) pop("tp4.r");
    for (int i = 0; i < 10; i++) push("tp4.w2", 8'(8'h50 + i));
    for (int i = 0; i < 10; i++) begin
      pop("tp4.r2");
      chk("tp4.order", 32'(bus.rd_data), 32'(8'h50 + i));
    end

    // Pop while empty.
    pop("tp5.empty_rd");
    chk("tp5.empty_v", 32'(bus.rd_valid), 0);
    chk("tp5.empty_d", 32'(bus.rd_data), 32'h59);

    // Flush beats a concurrent write and read.
    for (int i = 0; i < 5; i++) push("tp6.w", 8'($urandom));
    step("tp6.flush", 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
    chk("tp6.count", 32'(bus.count), 0);
    chk("tp6.empty", 32'(bus.empty), 1);
    chk("tp6.valid", 32'(bus.rd_valid), 0);
    chk("tp6.data", 32'(bus.rd_data), 32'h59);

    // Randomized traffic: write-heavy then read-heavy phases.
    for (int i = 0; i < 1200; i++) begin
      int unsigned wp;
      wp = (i < 600) ? 65 : 35;
      step("rnd",
           $urandom_range(99) < wp,
           8'($urandom),
           $urandom_range(99) >= wp,
           $urandom_range(99) < 2,
           $urandom_range(99) < 5);
    end

    // Async reset mid-burst, between clock edges.
    for (int i = 0; i < 18; i++) push("ar.fill", 8'($urandom));
    pop("ar.pop");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("ar.count",    32'(bus.count),    0);
    chk("ar.empty",    32'(bus.empty),    1);
    chk("ar.full",     32'(bus.full),     0);
    chk("ar.ovf",      32'(bus.ovf),      0);
    chk("ar.irq",      32'(bus.irq),      0);
    chk("ar.rd_valid", 32'(bus.rd_valid), 0);
    chk("ar.rd_data",  32'(bus.rd_data),  0);
    model_q.delete();
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    bus.rx_end = 1'b0;
    bus.rd_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    push("post.w", 8'h42);
    pop("post.r");
    chk("post.d", 32'(bus.rd_data), 32'h42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each byte on the receiver's one-cycle completion strobe and holds it in a circular FIFO until the CPU-side bus logic pops it through a read-request handshake. It also reports occupancy, a sticky overflow flag and a level interrupt, so software does not have to service every byte within one frame time.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2
- ADDR_W, 4, log2(DEPTH); pointer width
- IRQ_LEVEL, 1, irq asserts when count ≥ IRQ_LEVEL; range 1..DEPTH
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- rx_end  in  1  one-cycle strobe: rx_data holds a valid received byte
- rx_data  in  8  received byte, sampled only when rx_end=1
- flush  in  1  discard all stored bytes
- rd_req  in  1  pop request, one byte per cycle it is high
- rd_data  out  8  popped byte, registered
- rd_valid  out  1  one-cycle pulse: rd_data updated this cycle
- empty  out  1  count==0
- full  out  1  count==DEPTH
- count  out  ADDR_W+1  current occupancy 0..DEPTH
- ovf  out  1  sticky: a byte was dropped because the FIFO was full
- ovf_clr  in  1  clears ovf
- irq  out  1  level: (count ≥ IRQ_LEVEL) | ovf

## Operation
- Storage: DEPTH×8 array; wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH (DEPTH-1 → 0); count is an explicit register, not pointer difference.
- Write accept: rx_end & ~full → mem[wr_ptr]<=rx_data, wr_ptr+1.
- Write while full: rx_end & full & ~read-accept → byte dropped, pointers unchanged, ovf<=1.
- Read accept: rd_req & ~empty → rd_data<=mem[rd_ptr], rd_ptr+1, rd_valid<=1.
- Read while empty: rd_req & empty → ignored; rd_valid<=0, rd_data holds its previous value. No bypass: a byte written in the same cycle is not readable until the next cycle.
- Simultaneous write and read accept: both happen; count is unchanged. This includes the full case: the read frees a slot, the write is accepted, and ovf is not set.
- count update: +1 on write-only, −1 on read-only, unchanged otherwise; it never exceeds DEPTH and never goes below 0.
- flush: highest priority. Pointers and count go to 0, and rx_end and rd_req in the same cycle are ignored (rd_valid<=0). ovf and rd_data are unaffected.
- ovf_clr: ovf<=0, except that a new overflow event in the same cycle wins (ovf stays 1).
- empty, full and irq are combinational from the count and ovf registers (glitch-free).
- Reset values: rd_data=8'h00, rd_valid=0, count=0, empty=1, full=0, ovf=0, irq=0. wr_ptr=rd_ptr=0. Array contents are undefined and need not be reset.

## Timing
- Write latency: rx_end in cycle N → count/empty/full/irq reflect the byte at N+1; earliest pop request is N+1, with data valid at N+2.
- Read latency: rd_req in cycle N (not empty) → rd_data and rd_valid=1 at N+1; back-to-back rd_req yields one byte per cycle until empty.
- rd_valid is high exactly one cycle per accepted read; it is 0 on any cycle with no accepted read.
- rx_end is at most one cycle per byte. Consecutive rx_end cycles are legal and each is handled independently.
- Asynchronous reset mid-operation clears all state immediately. A pop in flight is lost and rd_valid goes low without waiting for clk.
- Sustained throughput: 1 write + 1 read per cycle.

## Test plan
- Reset, then push 8'hA5, 8'h3C via rx_end; pop twice → rd_data A5 then 3C with rd_valid one cycle after each rd_req; count 2→0; empty=1 at end.
- Push 16 bytes 8'h00..8'h0F → full=1, count=16. A 17th rx_end (8'hFF) → dropped, ovf=1, irq=1. Pop all 16 → 00..0F in order, FF never seen.
- FIFO full, rx_end(8'h77) and rd_req in the same cycle → read returns oldest byte, 77 accepted, count stays 16, ovf stays 0.
- Wrap: push 10 and pop 10 bytes, then push 10 (8'h50..8'h59) and pop 10 → 50..59 in order. Pointers wrap past 15 with no corruption.
- rd_req while empty → rd_valid=0, rd_data unchanged. ovf_clr coincident with an overflow event → ovf stays 1; ovf_clr alone → ovf=0.
- 5 bytes stored, flush asserted with rx_end and rd_req → count=0, empty=1, rd_valid=0, ovf unchanged. Async reset asserted between clk edges mid-burst → all outputs at reset values immediately.
